// File: rtl/score_keeper.sv
// score_keeper
// Tracks a two-player shooting game. One shot result is accepted per turn,
// the shooter's score is bumped on a hit, the result is held for
// HOLD_CYCLES before the turn passes, and the game ends when a score
// reaches WIN_SCORE.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   shot_valid game logic presents a shot result
//   shot_hit   1 = hit, 0 = miss (meaningful only on acceptance)
//   shot_ready keeper can accept a shot this cycle (state == PLAY)
//   new_game   single-cycle synchronous restart request
//   p1_score   player 1 score
//   p2_score   player 2 score
//   turn       current shooter: 0 = P1, 1 = P2
//   winner     00 none, 01 P1, 10 P2
//   game_over  high while in OVER
//   state      FSM state (PLAY=0, HOLD=1, OVER=2) for observation
//
// Handshake: a shot is accepted in a cycle where shot_valid and shot_ready
// are both high; shot_ready does not depend on shot_valid, and a presented
// shot may be held until it is accepted.
module score_keeper #(
  parameter int WIN_SCORE   = 3,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shot_valid,
  input  logic       shot_hit,
  output logic       shot_ready,
  input  logic       new_game,
  output logic [1:0] p1_score,
  output logic [1:0] p2_score,
  output logic       turn,
  output logic [1:0] winner,
  output logic       game_over,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

  // Counter counts HOLD_CYCLES-1 down to 0; keep at least one bit.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [1:0] WIN = 2'(WIN_SCORE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       p1_q, p1_d;
  logic [1:0]       p2_q, p2_d;
  logic             turn_q, turn_d;
  logic [1:0]       winner_q, winner_d;

  logic             accept;
  logic [1:0]       shooter_next;

  assign accept       = shot_valid && (state_q == PLAY);
  assign shooter_next = (turn_q ? p2_q : p1_q) + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PLAY;
      cnt_q    <= '0;
      p1_q     <= 2'd0;
      p2_q     <= 2'd0;
      turn_q   <= 1'b0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    turn_d   = turn_q;
    winner_d = winner_q;

    if (new_game) begin
      // Restart wins over anything else this cycle, including an accepted shot.
      state_d  = PLAY;
      cnt_d    = '0;
      p1_d     = 2'd0;
      p2_d     = 2'd0;
      turn_d   = 1'b0;
      winner_d = 2'b00;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (accept) begin
            if (shot_hit) begin
              if (turn_q) p2_d = shooter_next;
              else        p1_d = shooter_next;
            end
            if (shot_hit && (shooter_next == WIN)) begin
              state_d  = OVER;
              winner_d = turn_q ? 2'b10 : 2'b01;
            end else begin
              state_d = HOLD;
              cnt_d   = HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            turn_d  = ~turn_q;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        OVER: begin
          // Frozen until new_game or rst.
        end
        default: state_d = PLAY;
      endcase
    end
  end

  assign shot_ready = (state_q == PLAY);
  assign game_over  = (state_q == OVER);
  assign p1_score   = p1_q;
  assign p2_score   = p2_q;
  assign turn       = turn_q;
  assign winner     = winner_q;
  assign state      = state_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: WIN_SCORE=3, HOLD_CYCLES=4
  logic       valid_a, hit_a, ng_a, ready_a, turn_a, go_a;
  logic [1:0] p1_a, p2_a, win_a, st_a;
  // DUT B: WIN_SCORE=3, HOLD_CYCLES=1
  logic       valid_b, hit_b, ng_b, ready_b, turn_b, go_b;
  logic [1:0] p1_b, p2_b, win_b, st_b;
  // DUT C: WIN_SCORE=1, HOLD_CYCLES=4
  logic       valid_c, hit_c, ng_c, ready_c, turn_c, go_c;
  logic [1:0] p1_c, p2_c, win_c, st_c;

  score_keeper #(.WIN_SCORE(3), .HOLD_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .shot_valid(valid_a), .shot_hit(hit_a),
    .shot_ready(ready_a), .new_game(ng_a), .p1_score(p1_a), .p2_score(p2_a),
    .turn(turn_a), .winner(win_a), .game_over(go_a), .state(st_a)
  );

  score_keeper #(.WIN_SCORE(3), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .shot_valid(valid_b), .shot_hit(hit_b),
    .shot_ready(ready_b), .new_game(ng_b), .p1_score(p1_b), .p2_score(p2_b),
    .turn(turn_b), .winner(win_b), .game_over(go_b), .state(st_b)
  );

  score_keeper #(.WIN_SCORE(1), .HOLD_CYCLES(4)) dut_c (
    .clk(clk), .rst(rst), .shot_valid(valid_c), .shot_hit(hit_c),
    .shot_ready(ready_c), .new_game(ng_c), .p1_score(p1_c), .p2_score(p2_c),
    .turn(turn_c), .winner(win_c), .game_over(go_c), .state(st_c)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a();
    int n = 0;
    while (!ready_a && n < 20) begin
      step();
      n++;
    end
    check("a_ready_timeout", 32'(ready_a), 1);
  endtask

  // Present one shot on DUT A when ready; returns in the cycle after acceptance.
  task automatic shot_a(input logic hit);
    wait_ready_a();
    valid_a = 1'b1;
    hit_a   = hit;
    step();
    valid_a = 1'b0;
    hit_a   = 1'b0;
  endtask

  task automatic check_a(input string tag, input logic [1:0] p1, input logic [1:0] p2,
                         input logic t, input logic [1:0] w, input logic g, input logic r);
    check({tag, "_p1"},    32'(p1_a),    32'(p1));
    check({tag, "_p2"},    32'(p2_a),    32'(p2));
    check({tag, "_turn"},  32'(turn_a),  32'(t));
    check({tag, "_win"},   32'(win_a),   32'(w));
    check({tag, "_over"},  32'(go_a),    32'(g));
    check({tag, "_ready"}, 32'(ready_a), 32'(r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    valid_a = 0; hit_a = 0; ng_a = 0;
    valid_b = 0; hit_b = 0; ng_b = 0;
    valid_c = 0; hit_c = 0; ng_c = 0;
    step();
    check_a("rst_hold", 2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1);
    rst = 1'b0;
    step();
    step();
    check_a("idle", 2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1);
    check("idle_state", 32'(st_a), 0);

    // P1 hit, shot_valid held high through HOLD: no extra increment.
    valid_a = 1'b1;
    hit_a   = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      check_a($sformatf("hold%0d", k), 2'd1, 2'd0, 1'b0, 2'b00, 1'b0, 1'b0);
      if (k == 4) begin
        valid_a = 1'b0;
        hit_a   = 1'b0;
      end
      step();
    end
    check_a("hold_done", 2'd1, 2'd0, 1'b1, 2'b00, 1'b0, 1'b1);

    // new_game from PLAY with no shot
    ng_a = 1'b1;
    step();
    ng_a = 1'b0;
    check_a("ng1", 2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1);

    // P1 hit, P2 miss, P1 hit, P2 hit, P1 hit
    shot_a(1'b1); check_a("seq1", 2'd1, 2'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    shot_a(1'b0); check_a("seq2", 2'd1, 2'd0, 1'b1, 2'b00, 1'b0, 1'b0);
    shot_a(1'b1); check_a("seq3", 2'd2, 2'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    shot_a(1'b1); check_a("seq4", 2'd2, 2'd1, 1'b1, 2'b00, 1'b0, 1'b0);
    shot_a(1'b1); check_a("seq5", 2'd3, 2'd1, 1'b0, 2'b01, 1'b1, 1'b0);
    check("seq5_state", 32'(st_a), 2);

    // Shots in OVER are ignored.
    valid_a = 1'b1;
    hit_a   = 1'b1;
    for (int k = 0; k < 6; k++) step();
    valid_a = 1'b0;
    hit_a   = 1'b0;
    check_a("over_frozen", 2'd3, 2'd1, 1'b0, 2'b01, 1'b1, 1'b0);

    // new_game leaves OVER
    ng_a = 1'b1;
    step();
    ng_a = 1'b0;
    check_a("ng_over", 2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1);

    // new_game together with an accepted hit: the hit is discarded.
    ng_a = 1'b1; valid_a = 1'b1; hit_a = 1'b1;
    step();
    ng_a = 1'b0; valid_a = 1'b0; hit_a = 1'b0;
    check_a("ng_shot", 2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1);
    check("ng_shot_state", 32'(st_a), 0);

    // Build p2_score=2 and reset asynchronously mid-HOLD.
    shot_a(1'b0);
    shot_a(1'b1);
    shot_a(1'b0);
    shot_a(1'b1);
    check_a("p2_two", 2'd0, 2'd2, 1'b1, 2'b00, 1'b0, 1'b0);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_a("async_rst", 2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    step();
    check_a("post_rst", 2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1);

    // HOLD_CYCLES=1: ready again exactly two cycles after acceptance.
    valid_b = 1'b1;
    hit_b   = 1'b1;
    step();
    valid_b = 1'b0;
    hit_b   = 1'b0;
    check("b_n1_ready", 32'(ready_b), 0);
    check("b_n1_p1",    32'(p1_b),    1);
    check("b_n1_turn",  32'(turn_b),  0);
    step();
    check("b_n2_ready", 32'(ready_b), 1);
    check("b_n2_turn",  32'(turn_b),  1);
    check("b_n2_p2",    32'(p2_b),    0);

    // WIN_SCORE=1: P1 miss, then P2 hit wins.
    valid_c = 1'b1;
    hit_c   = 1'b0;
    step();
    valid_c = 1'b0;
    check("c_miss_ready", 32'(ready_c), 0);
    for (int k = 0; k < 4; k++) step();
    check("c_turn",  32'(turn_c),  1);
    check("c_ready", 32'(ready_c), 1);
    valid_c = 1'b1;
    hit_c   = 1'b1;
    step();
    valid_c = 1'b0;
    hit_c   = 1'b0;
    check("c_p2",    32'(p2_c),    1);
    check("c_p1",    32'(p1_c),    0);
    check("c_win",   32'(win_c),   2);
    check("c_over",  32'(go_c),    1);
    check("c_ready_over", 32'(ready_c), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
